// File: rtl/eth_mac_pkg.sv
// Shared Ethernet MAC constants, RX state encoding and byte-wide reflected CRC-32 step.
package eth_mac_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        DROP,
        IDLE,
        PREAMBLE,
        PAYLOAD
    } rx_state_t;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_mac_rx_if.sv
// AXI-stream beat bundle (no tready) carrying received frames toward the RX FIFO.
interface eth_mac_rx_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, tvalid, tlast, tuser);
    modport slave  (input  tdata, tvalid, tlast, tuser);

endinterface

// File: rtl/eth_mac_rx_crc32.sv
// Byte-wide CRC-32 register with synchronous re-init and enable; shared with the TX FCS generator.
module eth_crc32
    import eth_mac_pkg::*;
(
    input  logic        clk_125,
    input  logic        reset_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk_125 or negedge reset_n) begin
        if (!reset_n) begin
            crc <= CRC32_INIT;
        end else if (init) begin
            crc <= CRC32_INIT;
        end else if (en) begin
            crc <= crc32_byte(crc, data);
        end
    end

endmodule

// File: rtl/eth_mac_rx.sv
// Ethernet RX MAC: preamble/SFD strip, length and FCS check, AXI-stream output.
// Define ETH_MAC_RX_FCS_STRIP_EN to drop the 4 FCS bytes from the output stream.
module eth_mac_rx
    import eth_mac_pkg::*;
#(
    parameter int unsigned MIN_FRAME = 64,
    parameter int unsigned MAX_FRAME = 1518
) (
    input  logic         clk_125,
    input  logic         reset_n,
    input  logic [7:0]   gmii_rxd,
    input  logic         gmii_rx_dv,
    input  logic         gmii_rx_er,
    input  logic         gmii_rx_ce,
    eth_mac_rx_if.master m_rx_axis,
    output logic         rx_frame_done,
    output logic         rx_crc_err
);

`ifdef ETH_MAC_RX_FCS_STRIP_EN
    localparam int unsigned DEPTH = 5;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam logic [2:0]  FULL    = 3'(DEPTH);
    localparam logic [15:0] MIN_CNT = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_CNT = 16'(MAX_FRAME);

    rx_state_t   state_q, state_d;
    logic        start, accept, close, trunc;
    logic        beat, crc_bad, bad;
    logic [31:0] crc_q;
    logic [15:0] count_q;
    logic [2:0]  fill_q;
    logic        er_seen_q;
    logic [7:0]  pipe_q [DEPTH];

    eth_crc32 u_crc (
        .clk_125 (clk_125),
        .reset_n (reset_n),
        .init    (start),
        .en      (accept),
        .data    (gmii_rxd),
        .crc     (crc_q)
    );

    always_ff @(posedge clk_125 or negedge reset_n) begin
        if (!reset_n) state_q <= DROP;
        else          state_q <= state_d;
    end

    // DROP leaves on dv low regardless of the byte strobe.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        accept  = 1'b0;
        close   = 1'b0;
        trunc   = 1'b0;
        case (state_q)
            DROP: begin
                if (!gmii_rx_dv) state_d = IDLE;
            end
            IDLE, PREAMBLE: begin
                if (gmii_rx_ce) begin
                    if (!gmii_rx_dv) begin
                        state_d = IDLE;
                    end else if (gmii_rxd == ETH_PREAMBLE) begin
                        state_d = PREAMBLE;
                    end else if (gmii_rxd == ETH_SFD) begin
                        state_d = PAYLOAD;
                        start   = 1'b1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            PAYLOAD: begin
                if (gmii_rx_ce) begin
                    if (!gmii_rx_dv) begin
                        close   = 1'b1;
                        state_d = IDLE;
                    end else if (count_q >= MAX_CNT) begin
                        trunc   = 1'b1;
                        state_d = DROP;
                    end else begin
                        accept  = 1'b1;
                    end
                end
            end
            default: state_d = DROP;
        endcase
    end

    always_comb begin
        beat    = (accept || close || trunc) && (fill_q == FULL);
        crc_bad = (crc_q != CRC32_RESIDUE);
        bad     = trunc || crc_bad || er_seen_q || (count_q < MIN_CNT);
    end

    always_ff @(posedge clk_125 or negedge reset_n) begin
        if (!reset_n) begin
            m_rx_axis.tdata  <= '0;
            m_rx_axis.tvalid <= 1'b0;
            m_rx_axis.tlast  <= 1'b0;
            m_rx_axis.tuser  <= 1'b0;
            rx_frame_done    <= 1'b0;
            rx_crc_err       <= 1'b0;
            count_q          <= '0;
            fill_q           <= '0;
            er_seen_q        <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            m_rx_axis.tvalid <= beat;
            m_rx_axis.tdata  <= beat ? pipe_q[DEPTH-1] : '0;
            m_rx_axis.tlast  <= beat && (close || trunc);
            m_rx_axis.tuser  <= beat && (close || trunc) && bad;
            rx_frame_done    <= beat && (close || trunc);
            rx_crc_err       <= beat && close && crc_bad;
            if (start) begin
                count_q   <= '0;
                fill_q    <= '0;
                er_seen_q <= 1'b0;
            end
            if (accept) begin
                pipe_q[0] <= gmii_rxd;
                for (int unsigned i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
                if (fill_q != FULL)              fill_q  <= fill_q + 3'd1;
                if (count_q != MAX_CNT + 16'd1)  count_q <= count_q + 16'd1;
                if (gmii_rx_er)                  er_seen_q <= 1'b1;
            end
            if (close || trunc) fill_q <= '0;
        end
    end

endmodule

// File: tb/tb_eth_mac_rx.sv
// Directed self-checking bench for eth_mac_rx (honours ETH_MAC_RX_FCS_STRIP_EN).
module tb_eth_mac_rx;

`ifdef ETH_MAC_RX_FCS_STRIP_EN
    localparam int STRIP_N = 4;
`else
    localparam int STRIP_N = 0;
`endif

    logic       clk_125;
    logic       reset_n;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic       gmii_rx_ce;
    logic       rx_frame_done;
    logic       rx_crc_err;

    eth_mac_rx_if axis ();

    eth_mac_rx #(.MIN_FRAME(64), .MAX_FRAME(1518)) dut (
        .clk_125       (clk_125),
        .reset_n       (reset_n),
        .gmii_rxd      (gmii_rxd),
        .gmii_rx_dv    (gmii_rx_dv),
        .gmii_rx_er    (gmii_rx_er),
        .gmii_rx_ce    (gmii_rx_ce),
        .m_rx_axis     (axis),
        .rx_frame_done (rx_frame_done),
        .rx_crc_err    (rx_crc_err)
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int stray  = 0;

    logic [7:0] frm   [$];
    logic [7:0] bdata [$];
    logic       blast [$];
    logic       buser [$];
    logic       bcrc  [$];
    logic       bdone [$];
    int         bcyc  [$];

    initial begin
        clk_125 = 1'b0;
        forever #4 clk_125 = ~clk_125;
    end

    always @(posedge clk_125) cyc <= cyc + 1;

    always @(negedge clk_125) begin
        if (axis.tvalid) begin
            bdata.push_back(axis.tdata);
            blast.push_back(axis.tlast);
            buser.push_back(axis.tuser);
            bcrc.push_back(rx_crc_err);
            bdone.push_back(rx_frame_done);
            bcyc.push_back(cyc);
        end else if (axis.tlast || axis.tuser || rx_frame_done || rx_crc_err) begin
            stray++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d so far", passes, checks);
        $fatal(1);
    end

    task automatic clear_mon();
        bdata.delete(); blast.delete(); buser.delete();
        bcrc.delete();  bdone.delete(); bcyc.delete();
        stray = 0;
    endtask

    // Bench-side CRC: bit-serial LFSR, FCS transmitted LSB first.
    task automatic build_frame(input int n, input bit with_fcs);
        logic [31:0] c;
        logic        fb;
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'(i));
        if (with_fcs) begin
            c = 32'hFFFFFFFF;
            for (int k = 0; k < n; k++) begin
                for (int b = 0; b < 8; b++) begin
                    fb = c[0] ^ frm[k][b];
                    c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
                end
            end
            c = ~c;
            frm.push_back(c[7:0]);  frm.push_back(c[15:8]);
            frm.push_back(c[23:16]); frm.push_back(c[31:24]);
        end
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic dv, input logic er, input int period);
        @(negedge clk_125);
        gmii_rxd = d; gmii_rx_dv = dv; gmii_rx_er = er; gmii_rx_ce = 1'b1;
        for (int i = 1; i < period; i++) begin
            @(negedge clk_125);
            gmii_rx_ce = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_125);
            gmii_rxd = 8'h00; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rx_ce = 1'b1;
        end
    endtask

    task automatic send_frame(input int period, input int er_idx, input int gap);
        for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b1, 1'b0, period);
        drive_byte(8'hD5, 1'b1, 1'b0, period);
        foreach (frm[i]) drive_byte(frm[i], 1'b1, (i == er_idx), period);
        drive_byte(8'h00, 1'b0, 1'b0, period);
        idle(gap);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; gmii_rxd = '0; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rx_ce = 1'b1;
        repeat (3) @(negedge clk_125);
        checks++; if (axis.tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", axis.tvalid); else passes++;
        checks++; if (axis.tlast  !== 1'b0) $display("FAIL reset_tlast got %b want 0", axis.tlast); else passes++;
        checks++; if (axis.tuser  !== 1'b0) $display("FAIL reset_tuser got %b want 0", axis.tuser); else passes++;
        checks++; if (axis.tdata  !== 8'h00) $display("FAIL reset_tdata got %h want 00", axis.tdata); else passes++;
        checks++; if (rx_frame_done !== 1'b0) $display("FAIL reset_done got %b want 0", rx_frame_done); else passes++;
        checks++; if (rx_crc_err !== 1'b0) $display("FAIL reset_crc_err got %b want 0", rx_crc_err); else passes++;
        reset_n = 1'b1;
        idle(3);
    endtask

    task automatic test_good_frame();
        int n;
        int nl;
        clear_mon();
        build_frame(60, 1'b1);
        send_frame(1, -1, 4);
        n = 64 - STRIP_N;
        checks++; if (bdata.size() !== n) $display("FAIL good_beats got %0d want %0d", bdata.size(), n); else passes++;
        for (int i = 0; i < n && i < bdata.size(); i++) begin
            checks++; if (bdata[i] !== frm[i]) $display("FAIL good_data[%0d] got %h want %h", i, bdata[i], frm[i]); else passes++;
        end
        nl = 0;
        foreach (blast[i]) nl += int'(blast[i]);
        checks++; if (nl !== 1) $display("FAIL good_tlast_count got %0d want 1", nl); else passes++;
        if (bdata.size() > 0) begin
            checks++; if (blast[$] !== 1'b1) $display("FAIL good_tlast_pos got %b want 1", blast[$]); else passes++;
            checks++; if (buser[$] !== 1'b0) $display("FAIL good_tuser got %b want 0", buser[$]); else passes++;
            checks++; if (bdone[$] !== 1'b1) $display("FAIL good_done got %b want 1", bdone[$]); else passes++;
            checks++; if (bcrc[$] !== 1'b0) $display("FAIL good_crc_err got %b want 0", bcrc[$]); else passes++;
        end
        checks++; if (stray !== 0) $display("FAIL good_stray got %0d want 0", stray); else passes++;
    endtask

    task automatic test_crc_error();
        int n;
        clear_mon();
        build_frame(60, 1'b1);
        frm[10] = frm[10] ^ 8'h01;
        send_frame(1, -1, 4);
        n = 64 - STRIP_N;
        checks++; if (bdata.size() !== n) $display("FAIL crc_beats got %0d want %0d", bdata.size(), n); else passes++;
        if (bdata.size() > 10) begin
            checks++; if (bdata[10] !== 8'h0B) $display("FAIL crc_flipped_byte got %h want 0b", bdata[10]); else passes++;
        end
        if (bdata.size() > 0) begin
            checks++; if (blast[$] !== 1'b1) $display("FAIL crc_tlast got %b want 1", blast[$]); else passes++;
            checks++; if (buser[$] !== 1'b1) $display("FAIL crc_tuser got %b want 1", buser[$]); else passes++;
            checks++; if (bcrc[$] !== 1'b1) $display("FAIL crc_err got %b want 1", bcrc[$]); else passes++;
            checks++; if (bdone[$] !== 1'b1) $display("FAIL crc_done got %b want 1", bdone[$]); else passes++;
        end
    endtask

    task automatic test_slow_ce();
        int n;
        int errs;
        clear_mon();
        build_frame(60, 1'b1);
        send_frame(10, -1, 4);
        n = 64 - STRIP_N;
        checks++; if (bdata.size() !== n) $display("FAIL slow_beats got %0d want %0d", bdata.size(), n); else passes++;
        errs = 0;
        for (int i = 0; i < n && i < bdata.size(); i++) if (bdata[i] !== frm[i]) errs++;
        checks++; if (errs !== 0) $display("FAIL slow_data mismatching beats got %0d want 0", errs); else passes++;
        errs = 0;
        for (int i = 1; i < bcyc.size(); i++) if (bcyc[i] - bcyc[i-1] != 10) errs++;
        checks++; if (errs !== 0) $display("FAIL slow_spacing bad gaps got %0d want 0", errs); else passes++;
        if (bdata.size() > 0) begin
            checks++; if (buser[$] !== 1'b0) $display("FAIL slow_tuser got %b want 0", buser[$]); else passes++;
            checks++; if (bdone[$] !== 1'b1) $display("FAIL slow_done got %b want 1", bdone[$]); else passes++;
        end
    endtask

    task automatic test_rx_er();
        clear_mon();
        build_frame(60, 1'b1);
        send_frame(1, 20, 4);
        checks++; if (bdata.size() !== 64 - STRIP_N) $display("FAIL er_beats got %0d want %0d", bdata.size(), 64 - STRIP_N); else passes++;
        if (bdata.size() > 0) begin
            checks++; if (buser[$] !== 1'b1) $display("FAIL er_tuser got %b want 1", buser[$]); else passes++;
            checks++; if (bcrc[$] !== 1'b0) $display("FAIL er_crc_err got %b want 0", bcrc[$]); else passes++;
        end
    endtask

    task automatic test_short();
        clear_mon();
        build_frame(59, 1'b1);
        send_frame(1, -1, 4);
        checks++; if (bdata.size() !== 63 - STRIP_N) $display("FAIL short_beats got %0d want %0d", bdata.size(), 63 - STRIP_N); else passes++;
        if (bdata.size() > 0) begin
            checks++; if (buser[$] !== 1'b1) $display("FAIL short_tuser got %b want 1", buser[$]); else passes++;
            checks++; if (bcrc[$] !== 1'b0) $display("FAIL short_crc_err got %b want 0", bcrc[$]); else passes++;
        end
        clear_mon();
        frm.delete();
        send_frame(1, -1, 4);
        checks++; if (bdata.size() !== 0) $display("FAIL empty_beats got %0d want 0", bdata.size()); else passes++;
        checks++; if (stray !== 0) $display("FAIL empty_stray got %0d want 0", stray); else passes++;
    endtask

    task automatic test_oversize();
        int n;
        int nl;
        clear_mon();
        build_frame(1600, 1'b0);
        send_frame(1, -1, 4);
        n = 1518 - STRIP_N;
        checks++; if (bdata.size() !== n) $display("FAIL over_beats got %0d want %0d", bdata.size(), n); else passes++;
        nl = 0;
        foreach (blast[i]) nl += int'(blast[i]);
        checks++; if (nl !== 1) $display("FAIL over_tlast_count got %0d want 1", nl); else passes++;
        if (bdata.size() > 0) begin
            checks++; if (bdata[$] !== frm[n-1]) $display("FAIL over_last_data got %h want %h", bdata[$], frm[n-1]); else passes++;
            checks++; if (blast[$] !== 1'b1) $display("FAIL over_tlast got %b want 1", blast[$]); else passes++;
            checks++; if (buser[$] !== 1'b1) $display("FAIL over_tuser got %b want 1", buser[$]); else passes++;
            checks++; if (bcrc[$] !== 1'b0) $display("FAIL over_crc_err got %b want 0", bcrc[$]); else passes++;
            checks++; if (bdone[$] !== 1'b1) $display("FAIL over_done got %b want 1", bdone[$]); else passes++;
        end
        clear_mon();
        build_frame(60, 1'b1);
        send_frame(1, -1, 4);
        checks++; if (bdata.size() !== 64 - STRIP_N) $display("FAIL after_over_beats got %0d want %0d", bdata.size(), 64 - STRIP_N); else passes++;
        if (bdata.size() > 0) begin
            checks++; if (buser[$] !== 1'b0) $display("FAIL after_over_tuser got %b want 0", buser[$]); else passes++;
        end
    endtask

    task automatic test_bad_preamble();
        clear_mon();
        build_frame(60, 1'b1);
        for (int i = 0; i < 3; i++) drive_byte(8'h55, 1'b1, 1'b0, 1);
        drive_byte(8'h5A, 1'b1, 1'b0, 1);
        for (int i = 0; i < 3; i++) drive_byte(8'h55, 1'b1, 1'b0, 1);
        drive_byte(8'hD5, 1'b1, 1'b0, 1);
        foreach (frm[i]) drive_byte(frm[i], 1'b1, 1'b0, 1);
        drive_byte(8'h00, 1'b0, 1'b0, 1);
        idle(4);
        checks++; if (bdata.size() !== 0) $display("FAIL badpre_beats got %0d want 0", bdata.size()); else passes++;
        checks++; if (stray !== 0) $display("FAIL badpre_stray got %0d want 0", stray); else passes++;
    endtask

    task automatic test_reset_mid();
        clear_mon();
        build_frame(60, 1'b1);
        for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b1, 1'b0, 1);
        drive_byte(8'hD5, 1'b1, 1'b0, 1);
        for (int i = 0; i < 20; i++) drive_byte(frm[i], 1'b1, 1'b0, 1);
        @(negedge clk_125);
        reset_n = 1'b0;
        drive_byte(frm[20], 1'b1, 1'b0, 1);
        checks++; if (axis.tvalid !== 1'b0) $display("FAIL midrst_tvalid got %b want 0", axis.tvalid); else passes++;
        drive_byte(frm[21], 1'b1, 1'b0, 1);
        reset_n = 1'b1;
        clear_mon();
        for (int i = 22; i < frm.size(); i++) drive_byte(frm[i], 1'b1, 1'b0, 1);
        drive_byte(8'h00, 1'b0, 1'b0, 1);
        idle(4);
        checks++; if (bdata.size() !== 0) $display("FAIL midrst_beats got %0d want 0", bdata.size()); else passes++;
        checks++; if (stray !== 0) $display("FAIL midrst_stray got %0d want 0", stray); else passes++;
        clear_mon();
        send_frame(1, -1, 4);
        checks++; if (bdata.size() !== 64 - STRIP_N) $display("FAIL midrst_recover got %0d want %0d", bdata.size(), 64 - STRIP_N); else passes++;
    endtask

    task automatic test_back_to_back();
        int n;
        int nl;
        int nu;
        int nd;
        int errs;
        clear_mon();
        build_frame(60, 1'b1);
        send_frame(1, -1, 0);
        send_frame(1, -1, 4);
        n = 64 - STRIP_N;
        checks++; if (bdata.size() !== 2 * n) $display("FAIL b2b_beats got %0d want %0d", bdata.size(), 2 * n); else passes++;
        nl = 0; nu = 0; nd = 0;
        foreach (blast[i]) begin
            nl += int'(blast[i]); nu += int'(buser[i]); nd += int'(bdone[i]);
        end
        checks++; if (nl !== 2) $display("FAIL b2b_tlast_count got %0d want 2", nl); else passes++;
        checks++; if (nu !== 0) $display("FAIL b2b_tuser_count got %0d want 0", nu); else passes++;
        checks++; if (nd !== 2) $display("FAIL b2b_done_count got %0d want 2", nd); else passes++;
        errs = 0;
        for (int i = 0; i < n && n + i < bdata.size(); i++) if (bdata[n+i] !== frm[i]) errs++;
        checks++; if (errs !== 0) $display("FAIL b2b_second_data mismatching beats got %0d want 0", errs); else passes++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_crc_error();
        test_slow_ce();
        test_rx_er();
        test_short();
        test_oversize();
        test_bad_preamble();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
